// File: rtl/rot_quad_fetch_pkg.sv
// rtl/rot_quad_fetch_pkg.sv - shared types for the rotated quad fetcher
// Contents: quad/fraction widths, issue tag layout, FSM state encoding.
package rot_pkg;

  localparam int QUAD_W = 64;
  localparam int FRAC_W = 8;

  // One tag per issued output pixel, in raster order.
  typedef struct packed {
    logic              oob;
    logic [FRAC_W-1:0] frac_u;
    logic [FRAC_W-1:0] frac_v;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rot_quad_fetch_fifo.sv
// rtl/rot_quad_fetch_fifo.sv - synchronous first-word-fall-through FIFO
// Ports: clk, rst (sync, active-high), push/din write side,
//        pop/dout read side (dout valid while !empty), full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO is still taken when the head is popped the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rot_quad_fetch.sv
// rtl/rot_quad_fetch.sv - rotated raster walker issuing 2x2 quad reads for the bilinear filter
// Ports: clk, rst; start/cos_q/sin_q/u0/v0 frame setup; busy, frame_done status;
//        rd_req/rd_addr/rd_ready request side, rd_data/rd_data_valid return side;
//        pixelx4/decimal/pixelx4_valid output to the filter.
module rot_quad_fetch
  import rot_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int ADDR_W  = 19,
  parameter int COORD_W = 24,
  parameter int OUTST   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [9:0]          cos_q,
  input  logic [9:0]          sin_q,
  input  logic [COORD_W-1:0]  u0,
  input  logic [COORD_W-1:0]  v0,
  output logic                busy,
  output logic                frame_done,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_ready,
  input  logic [QUAD_W-1:0]   rd_data,
  input  logic                rd_data_valid,
  output logic [QUAD_W-1:0]   pixelx4,
  output logic [15:0]         decimal,
  output logic                pixelx4_valid
);

  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int IW    = COORD_W - FRAC_W;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [XW-1:0]        X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(IMG_H - 1);
  localparam logic signed [IW-1:0] U_MAX  = IW'(IMG_W - 2);
  localparam logic signed [IW-1:0] V_MAX  = IW'(IMG_H - 2);

  state_t state, state_nx;
  logic   frame_done_nx;

  logic signed [COORD_W-1:0] cos_r, sin_r, u, v, row_u, row_v;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;
  logic [CW-1:0]             emit_cnt;

  logic signed [IW-1:0] u_int, v_int;
  logic                 oob, issue, last_col, last_row;
  logic [ADDR_W-1:0]    addr_calc;

  tag_t              tag_din, tag_dout;
  logic              tag_full, tag_empty, tag_pop;
  logic [QUAD_W-1:0] data_dout;
  logic              data_full, data_empty, data_pop;

  assign u_int    = u[COORD_W-1:FRAC_W];
  assign v_int    = v[COORD_W-1:FRAC_W];
  // The quad needs columns u_int..u_int+1 and rows v_int..v_int+1 inside the frame.
  assign oob      = u_int[IW-1] | (u_int > U_MAX) | v_int[IW-1] | (v_int > V_MAX);
  assign last_col = (x == X_LAST);
  assign last_row = (y == Y_LAST);
  assign addr_calc = ADDR_W'(v_int) * ADDR_W'(IMG_W) + ADDR_W'(u_int);

  // OOB pixels consume an issue slot without touching memory.
  assign issue   = (state == RUN) & ~tag_full & (oob | rd_ready);
  assign rd_req  = (state == RUN) & ~oob & ~tag_full;
  assign rd_addr = rd_req ? addr_calc : '0;
  assign busy    = (state != IDLE);

  assign tag_din = '{oob: oob, frac_u: u[FRAC_W-1:0], frac_v: v[FRAC_W-1:0]};

  // An in-bounds head tag waits for its data; OOB tags behind it wait too.
  assign tag_pop  = ~tag_empty & (tag_dout.oob | ~data_empty);
  assign data_pop = ~tag_empty & ~tag_dout.oob & ~data_empty;

  sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (tag_din),
    .pop   (tag_pop),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sync_fifo #(.WIDTH(QUAD_W), .DEPTH(OUTST)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_data_valid),
    .din   (rd_data),
    .pop   (data_pop),
    .dout  (data_dout),
    .full  (data_full),
    .empty (data_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    frame_done_nx = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (issue && last_col && last_row) state_nx = DRAIN;
      DRAIN: begin
        if (emit_cnt == CW'(TOTAL)) begin
          state_nx      = IDLE;
          frame_done_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cos_r         <= '0;
      sin_r         <= '0;
      u             <= '0;
      v             <= '0;
      row_u         <= '0;
      row_v         <= '0;
      x             <= '0;
      y             <= '0;
      emit_cnt      <= '0;
      pixelx4       <= '0;
      decimal       <= '0;
      pixelx4_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done    <= frame_done_nx;
      pixelx4_valid <= tag_pop;
      if (state == IDLE && start) begin
        cos_r    <= {{(COORD_W-10){cos_q[9]}}, cos_q};
        sin_r    <= {{(COORD_W-10){sin_q[9]}}, sin_q};
        u        <= u0;
        v        <= v0;
        row_u    <= u0;
        row_v    <= v0;
        x        <= '0;
        y        <= '0;
        emit_cnt <= '0;
      end else if (issue) begin
        if (!last_col) begin
          u <= u + cos_r;
          v <= v + sin_r;
          x <= x + 1'b1;
        end else begin
          // Step the row origin along the rotated y axis: (-sin, +cos).
          row_u <= row_u - sin_r;
          row_v <= row_v + cos_r;
          u     <= row_u - sin_r;
          v     <= row_v + cos_r;
          x     <= '0;
          y     <= y + 1'b1;
        end
      end
      if (tag_pop) begin
        emit_cnt <= emit_cnt + 1'b1;
        pixelx4  <= tag_dout.oob ? '0 : data_dout;
        decimal  <= tag_dout.oob ? 16'h0000 : {tag_dout.frac_u, tag_dout.frac_v};
      end
    end
  end

  // Data in flight never exceeds issued in-bounds tags, so this must never fire.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(rd_data_valid && data_full && !data_pop));
  end

endmodule
